tlb_refill_walker: RTL and testbench

//  Refill engine for the 2-way TLB tag RAM: on a lookup miss it walks a two-level
//  Sv32-style page table through a single-outstanding memory read port.
//  It then writes the leaf PTE into the tag RAM (we/valid_i/idx/tag/payload_i).

---
 rtl/tlb_refill_walker.sv | 144 ++++++++++++++
 tb/tb_tlb_refill_walker.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tlb_refill_walker.sv
// Two-level Sv32-style page-table walker that refills the 2-way TLB tag RAM on a miss.
// One memory read is outstanding at a time; faults skip the fill and report through done.
module tlb_refill_walker #(
  parameter int TAG_RAM_ADDR_WIDTH = 6,
  parameter int TAG_WIDTH          = 20,
  parameter int PAYLOAD_WIDTH      = 32,
  parameter int PADDR_WIDTH        = 32
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [PADDR_WIDTH-1:0]        root_base,
  input  logic                          miss_valid,
  output logic                          miss_ready,
  input  logic [19:0]                   miss_vpn,
  output logic                          mem_req_valid,
  input  logic                          mem_req_ready,
  output logic [PADDR_WIDTH-1:0]        mem_req_addr,
  input  logic                          mem_rsp_valid,
  input  logic [31:0]                   mem_rsp_data,
  output logic                          fill_valid,
  output logic                          fill_we,
  output logic [TAG_RAM_ADDR_WIDTH-1:0] fill_idx,
  output logic [TAG_WIDTH-1:0]          fill_tag,
  output logic [PAYLOAD_WIDTH-1:0]      fill_payload,
  output logic                          done_valid,
  output logic                          done_fault,
  input  logic                          done_ready
);

  typedef enum logic [2:0] {
    IDLE, L1_REQ, L1_WAIT, L0_REQ, L0_WAIT, FILL, DONE
  } state_t;

  state_t                   state, state_nxt;
  logic [19:0]              vpn_q, vpn_nxt;
  logic [PADDR_WIDTH-1:0]   addr_q, addr_nxt;
  logic [PAYLOAD_WIDTH-1:0] payload_q, payload_nxt;
  logic                     fault_q, fault_nxt;

  logic pte_v, pte_r, pte_w, pte_x, pte_bad, pte_leaf, pte_misaligned;

  assign pte_v          = mem_rsp_data[0];
  assign pte_r          = mem_rsp_data[1];
  assign pte_w          = mem_rsp_data[2];
  assign pte_x          = mem_rsp_data[3];
  assign pte_bad        = !pte_v || (!pte_r && pte_w);
  assign pte_leaf       = pte_r || pte_x;
  assign pte_misaligned = |mem_rsp_data[19:10];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      vpn_q     <= '0;
      addr_q    <= '0;
      payload_q <= '0;
      fault_q   <= 1'b0;
    end else begin
      state     <= state_nxt;
      vpn_q     <= vpn_nxt;
      addr_q    <= addr_nxt;
      payload_q <= payload_nxt;
      fault_q   <= fault_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    vpn_nxt       = vpn_q;
    addr_nxt      = addr_q;
    payload_nxt   = payload_q;
    fault_nxt     = fault_q;
    miss_ready    = 1'b0;
    mem_req_valid = 1'b0;
    mem_req_addr  = '0;
    fill_valid    = 1'b0;
    fill_we       = 1'b0;
    fill_idx      = '0;
    fill_tag      = '0;
    fill_payload  = '0;
    done_valid    = 1'b0;
    done_fault    = 1'b0;

    case (state)
      IDLE: begin
        miss_ready = 1'b1;
        if (miss_valid) begin
          // root_base is consumed here, so later changes cannot disturb the walk
          vpn_nxt   = miss_vpn;
          addr_nxt  = (root_base & {{(PADDR_WIDTH-12){1'b1}}, 12'h000})
                    + {{(PADDR_WIDTH-12){1'b0}}, miss_vpn[19:10], 2'b00};
          fault_nxt = 1'b0;
          state_nxt = L1_REQ;
        end
      end
      L1_REQ, L0_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = addr_q;
        if (mem_req_ready) state_nxt = (state == L1_REQ) ? L1_WAIT : L0_WAIT;
      end
      L1_WAIT: begin
        if (mem_rsp_valid) begin
          if (pte_bad || (pte_leaf && pte_misaligned)) begin
            fault_nxt = 1'b1;
            state_nxt = DONE;
          end else if (pte_leaf) begin
            // Superpage: low VPN bits pass through into the PPN field of the fill
            payload_nxt = {mem_rsp_data[31:20], vpn_q[9:0], mem_rsp_data[9:0]};
            state_nxt   = FILL;
          end else begin
            addr_nxt  = {mem_rsp_data[PADDR_WIDTH-3:10], 12'h000}
                      + {{(PADDR_WIDTH-12){1'b0}}, vpn_q[9:0], 2'b00};
            state_nxt = L0_REQ;
          end
        end
      end
      L0_WAIT: begin
        if (mem_rsp_valid) begin
          if (pte_bad || !pte_leaf) begin
            fault_nxt = 1'b1;
            state_nxt = DONE;
          end else begin
            payload_nxt = mem_rsp_data;
            state_nxt   = FILL;
          end
        end
      end
      FILL: begin
        fill_valid   = 1'b1;
        fill_we      = 1'b1;
        fill_idx     = vpn_q[TAG_RAM_ADDR_WIDTH-1:0];
        fill_tag     = vpn_q;
        fill_payload = payload_q;
        state_nxt    = DONE;
      end
      DONE: begin
        done_valid = 1'b1;
        done_fault = fault_q;
        if (done_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_tlb_refill_walker.sv
// Randomized bench for tlb_refill_walker: a bench-side memory serves PTEs and every walk
// is compared with a page-walk model computed directly from the translation rules.
module tb_tlb_refill_walker;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] root_base;
  logic        miss_valid;
  logic        miss_ready;
  logic [19:0] miss_vpn;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        fill_valid;
  logic        fill_we;
  logic [5:0]  fill_idx;
  logic [19:0] fill_tag;
  logic [31:0] fill_payload;
  logic        done_valid;
  logic        done_fault;
  logic        done_ready;

  int n_cmp = 0;
  int n_bad = 0;

  tlb_refill_walker dut (
    .clk(clk), .resetn(resetn), .root_base(root_base),
    .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_vpn(miss_vpn),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .fill_valid(fill_valid), .fill_we(fill_we), .fill_idx(fill_idx), .fill_tag(fill_tag),
    .fill_payload(fill_payload), .done_valid(done_valid), .done_fault(done_fault),
    .done_ready(done_ready)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic pte_ok(input logic [31:0] p);
    return p[0] && !(!p[1] && p[2]);
  endfunction

  function automatic logic pte_leaf(input logic [31:0] p);
    return p[1] || p[3];
  endfunction

  // Reference page walk from the translation rules, in plain integer arithmetic
  function automatic void model_walk(input logic [31:0] root, input logic [19:0] vpn,
                                     input logic [31:0] l1, input logic [31:0] l0,
                                     output int n_req, output logic [31:0] a1,
                                     output logic [31:0] a2, output logic [31:0] pay,
                                     output logic flt);
    logic [31:0] vpn1, vpn0;
    vpn1  = {12'd0, vpn} / 1024;
    vpn0  = {12'd0, vpn} % 1024;
    a1    = (root / 4096) * 4096 + vpn1 * 4;
    a2    = 0;
    pay   = 0;
    flt   = 1'b0;
    n_req = 1;
    if (!pte_ok(l1)) flt = 1'b1;
    else if (pte_leaf(l1)) begin
      if ((l1 / 1024) % 1024 != 0) flt = 1'b1;
      else pay = (l1 / 1048576) * 1048576 + vpn0 * 1024 + l1 % 1024;
    end else begin
      n_req = 2;
      a2    = ((l1 / 1024) % 1048576) * 4096 + vpn0 * 4;
      if (!pte_ok(l0) || !pte_leaf(l0)) flt = 1'b1;
      else pay = l0;
    end
  endfunction

  function automatic logic [31:0] rand_pte(input int kind);
    logic [31:0] p;
    p = $urandom;
    case (kind)
      0: p[0] = 1'b0;
      1: begin p[0] = 1'b1; p[1] = 1'b0; p[2] = 1'b1; end
      2: begin p[0] = 1'b1; p[1] = 1'b0; p[2] = 1'b0; p[3] = 1'b0; end
      3, 4: begin
        p[0] = 1'b1;
        p[1] = $urandom_range(0, 1);
        p[3] = p[1] ? 1'($urandom_range(0, 1)) : 1'b1;
        p[2] = p[1] ? 1'($urandom_range(0, 1)) : 1'b0;
        if (kind == 3) p[19:10] = 10'd0;
        else if (p[19:10] == 10'd0) p[10] = 1'b1;
      end
      default: ;
    endcase
    return p;
  endfunction

  // Runs one walk from a sample slot in IDLE; returns at the slot after the done handshake
  task automatic applyStimulus(input string name, input logic [31:0] root, input logic [19:0] vpn,
                               input logic [31:0] l1, input logic [31:0] l0,
                               input int req_stall, input int rsp_delay, input int done_stall,
                               input bit hold_valid, input int exp_fill_cyc, input int exp_done_cyc);
    int n_req_exp, reqs, fills, leak, unstable, busy, stall_left, rsp_cnt, done_wait;
    int cyc, fill_cyc, done_cyc;
    logic [31:0] a1, a2, pay, addrs[2], f_idx, f_tag, f_pay, prev_addr;
    logic flt, got_fault, prev_stall, rsp_pending, finished;
    model_walk(root, vpn, l1, l0, n_req_exp, a1, a2, pay, flt);
    reqs = 0; fills = 0; leak = 0; unstable = 0; busy = 0; done_wait = 0; rsp_cnt = 0;
    fill_cyc = -1; done_cyc = -1; prev_stall = 0; rsp_pending = 0; finished = 0;
    got_fault = 0; prev_addr = 0; addrs[0] = 0; addrs[1] = 0;
    f_idx = 0; f_tag = 0; f_pay = 0;
    stall_left = req_stall;
    miss_valid = 1'b1; miss_vpn = vpn; root_base = root;
    checkOutput({name, "_accept_ready"}, {31'd0, miss_ready}, 32'd1);
    tick();
    if (!hold_valid) miss_valid = 1'b0;
    miss_vpn = 20'($urandom); root_base = $urandom;
    cyc = 1;
    while (!finished && cyc <= 200) begin
      mem_rsp_valid = 1'b0;
      if (rsp_pending) begin
        if (rsp_cnt == 0) begin
          mem_rsp_valid = 1'b1;
          mem_rsp_data  = (reqs == 1) ? l1 : l0;
          rsp_pending   = 0;
        end else rsp_cnt--;
      end
      if (miss_ready) busy++;
      if (mem_req_valid) begin
        if (prev_stall && mem_req_addr !== prev_addr) unstable++;
        if (stall_left > 0) begin
          mem_req_ready = 1'b0; stall_left--; prev_stall = 1; prev_addr = mem_req_addr;
        end else begin
          mem_req_ready = 1'b1;
          if (reqs < 2) addrs[reqs] = mem_req_addr;
          reqs++; prev_stall = 0; rsp_pending = 1; rsp_cnt = rsp_delay; stall_left = req_stall;
        end
      end else begin
        if (prev_stall) unstable++;
        prev_stall = 0;
        mem_req_ready = 1'($urandom_range(0, 1));
      end
      if (fill_valid) begin
        fills++; fill_cyc = cyc;
        f_idx = {26'd0, fill_idx}; f_tag = {12'd0, fill_tag}; f_pay = fill_payload;
        if (!fill_we) leak++;
      end else if (fill_we || fill_idx != 0 || fill_tag != 0 || fill_payload != 0) leak++;
      if (done_fault && !done_valid) leak++;
      if (done_valid) begin
        if (done_cyc < 0) done_cyc = cyc;
        else if (done_fault !== got_fault) unstable++;
        got_fault = done_fault;
        if (done_wait < done_stall) begin done_ready = 1'b0; done_wait++; end
        else begin done_ready = 1'b1; finished = 1; end
      end else done_ready = 1'($urandom_range(0, 1));
      if ((fill_valid || done_valid) && !mem_rsp_valid) begin
        mem_rsp_valid = 1'($urandom_range(0, 1));
        mem_rsp_data  = $urandom;
      end
      tick();
      cyc++;
    end
    mem_rsp_valid = 1'b0; mem_req_ready = 1'b0; done_ready = 1'b0;
    if (!finished) checkOutput({name, "_timeout"}, 32'd0, 32'd1);
    checkOutput({name, "_req_count"}, reqs, n_req_exp);
    checkOutput({name, "_req_addr1"}, addrs[0], a1);
    if (n_req_exp == 2) checkOutput({name, "_req_addr2"}, addrs[1], a2);
    checkOutput({name, "_fill_count"}, fills, flt ? 0 : 1);
    if (!flt && fills == 1) begin
      checkOutput({name, "_fill_idx"}, f_idx, {12'd0, vpn} % 64);
      checkOutput({name, "_fill_tag"}, f_tag, {12'd0, vpn});
      checkOutput({name, "_fill_payload"}, f_pay, pay);
    end
    checkOutput({name, "_done_fault"}, {31'd0, got_fault}, {31'd0, flt});
    checkOutput({name, "_idle_outputs_leak"}, leak, 0);
    checkOutput({name, "_held_stable"}, unstable, 0);
    checkOutput({name, "_miss_ready_busy"}, busy, 0);
    if (exp_fill_cyc > 0) checkOutput({name, "_fill_latency"}, fill_cyc, exp_fill_cyc);
    if (exp_done_cyc > 0) checkOutput({name, "_done_latency"}, done_cyc, exp_done_cyc);
  endtask

  initial begin
    int viol;
    resetn = 1'b0; root_base = 0; miss_valid = 0; miss_vpn = 0; mem_req_ready = 0;
    mem_rsp_valid = 0; mem_rsp_data = 0; done_ready = 0;
    tick(); tick();
    checkOutput("rst_miss_ready", {31'd0, miss_ready}, 32'd1);
    checkOutput("rst_req", {31'd0, mem_req_valid} | mem_req_addr, 32'd0);
    checkOutput("rst_fill", {fill_valid, fill_we, 30'd0} | {26'd0, fill_idx} | {12'd0, fill_tag}
                            | fill_payload, 32'd0);
    checkOutput("rst_done", {30'd0, done_valid, done_fault}, 32'd0);
    resetn = 1'b1;
    tick();

    applyStimulus("t1", 32'h8000_0000, 20'h12345, 32'h2000_0001, 32'h1234_50CF, 0, 0, 0, 0, 5, 6);
    applyStimulus("t2", 32'h8000_0000, 20'h00ABC, 32'h4000_000F, 32'h0, 0, 0, 0, 0, 3, 4);
    applyStimulus("t3a", 32'h8000_0000, 20'h12345, 32'h0000_0000, 32'h0, 0, 0, 0, 0, 0, 0);
    applyStimulus("t3b", 32'h8000_0000, 20'h12345, 32'h0000_0405, 32'h0, 0, 0, 0, 0, 0, 0);
    applyStimulus("t3c", 32'h8000_0000, 20'h12345, 32'h2000_040B, 32'h0, 0, 0, 0, 0, 0, 0);
    applyStimulus("t4", 32'h8000_0000, 20'h12345, 32'h2000_0001, 32'h1234_50CF, 5, 0, 3, 0, 0, 0);

    // Reset during L0_WAIT, then a late response that must be ignored
    miss_valid = 1'b1; miss_vpn = 20'h12345; root_base = 32'h8000_0000; mem_req_ready = 1'b1;
    tick();
    miss_valid = 1'b0;
    tick();
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h2000_0001;
    tick();
    mem_rsp_valid = 1'b0;
    tick();
    resetn = 1'b0;
    tick();
    resetn = 1'b1; mem_rsp_valid = 1'b1; mem_rsp_data = 32'h1234_50CF;
    viol = 0;
    for (int i = 0; i < 5; i++) begin
      if (fill_valid || done_valid || mem_req_valid || !miss_ready) viol++;
      tick();
      mem_rsp_valid = 1'b0;
    end
    mem_req_ready = 1'b0;
    checkOutput("t5_quiet_after_reset", viol, 0);
    applyStimulus("t5_next", 32'h8000_0000, 20'h12345, 32'h2000_0001, 32'h1234_50CF, 0, 0, 0, 0, 5, 6);

    applyStimulus("t6a", 32'h0001_2000, 20'h0F00F, 32'h0003_4001, 32'h0ABC_D0C3, 1, 1, 1, 1, 0, 0);
    applyStimulus("t6b", 32'h0001_2000, 20'h00ABC, 32'h4000_000F, 32'h0, 0, 0, 0, 1, 3, 4);
    miss_valid = 1'b0;

    for (int i = 0; i < 40; i++) begin
      applyStimulus("rnd", $urandom, 20'($urandom), rand_pte($urandom_range(0, 5)),
                    rand_pte($urandom_range(0, 5)), $urandom_range(0, 3), $urandom_range(0, 2),
                    $urandom_range(0, 3), 0, 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
